// File: rtl/fp_special_ctrl.sv
// Control unit for a floating-point multiplier: short-circuits special operands (NaN/Inf/zero) and
// sequences normal requests through the datapath. Define FP_SPECIAL_BYPASS_EN to skip the datapath for specials.
module fp_special_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [4:0]       in_a_flags,
    input  logic [4:0]       in_b_flags,
    input  logic [TAG_W-1:0] in_tag,
    output logic             dp_start,
    output logic [1:0]       dp_op,
    output logic [TAG_W-1:0] dp_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_bypass,
    output logic             out_sign,
    output logic             out_nan,
    output logic             out_inf,
    output logic             out_zero,
    input  logic             flush
);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_INV_S = 2'b01;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             dp_start_q, dp_start_d;
    logic             bypass_q, bypass_d;
    logic             sign_q, sign_d;
    logic             nan_q, nan_d;
    logic             inf_q, inf_d;
    logic             zero_q, zero_d;

    // Flag vectors are {sign, val, nan, inf, zero}; the val bit plays no part in classification.
    logic a_sign, a_nan, a_inf, a_zero;
    logic b_sign, b_nan, b_inf, b_zero;
    logic unused_val;
    logic c_sign, c_nan, c_inf, c_zero, c_special;
    logic accept;

    assign a_sign     = in_a_flags[4];
    assign a_nan      = in_a_flags[2];
    assign a_inf      = in_a_flags[1];
    assign a_zero     = in_a_flags[0];
    assign b_sign     = in_b_flags[4];
    assign b_nan      = in_b_flags[2];
    assign b_inf      = in_b_flags[1];
    assign b_zero     = in_b_flags[0];
    assign unused_val = in_a_flags[3] ^ in_b_flags[3];

    always_comb begin
        c_sign = 1'b0;
        case (in_op)
            OP_MUL:   c_sign = a_sign ^ b_sign;
            OP_INV_S: c_sign = ~(a_sign ^ b_sign);
            default:  c_sign = 1'b0;
        endcase
        c_nan     = a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero) | (in_op == OP_RSVD);
        c_inf     = ~c_nan & (a_inf | b_inf);
        c_zero    = ~c_nan & ~c_inf & (a_zero | b_zero);
        c_special = c_nan | c_inf | c_zero;
    end

    assign in_ready = (state_q == IDLE);
    // A request offered alongside flush is dropped: flush wins and the state stays IDLE.
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        tag_d      = tag_q;
        dp_start_d = 1'b0;
        bypass_d   = bypass_q;
        sign_d     = sign_q;
        nan_d      = nan_q;
        inf_d      = inf_q;
        zero_d     = zero_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d     = in_op;
                    tag_d    = in_tag;
                    sign_d   = c_sign;
                    nan_d    = c_nan;
                    inf_d    = c_inf;
                    zero_d   = c_zero;
                    bypass_d = c_special;
`ifdef FP_SPECIAL_BYPASS_EN
                    if (c_special) begin
                        state_d = HOLD;
                    end else begin
                        state_d    = BUSY;
                        dp_start_d = 1'b1;
                        cnt_d      = 4'(MUL_LAT);
                    end
`else
                    state_d    = BUSY;
                    dp_start_d = 1'b1;
                    cnt_d      = 4'(MUL_LAT);
`endif
                end
            end
            BUSY: begin
                // Counter is live for MUL_LAT cycles; the result is presented once it hits zero.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d    = IDLE;
            cnt_d      = 4'd0;
            dp_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            op_q       <= 2'b00;
            tag_q      <= '0;
            dp_start_q <= 1'b0;
            bypass_q   <= 1'b0;
            sign_q     <= 1'b0;
            nan_q      <= 1'b0;
            inf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            dp_start_q <= dp_start_d;
            bypass_q   <= bypass_d;
            sign_q     <= sign_d;
            nan_q      <= nan_d;
            inf_q      <= inf_d;
            zero_q     <= zero_d;
        end
    end

    assign dp_start   = dp_start_q;
    assign dp_op      = op_q;
    assign dp_tag     = tag_q;
    assign out_valid  = (state_q == HOLD);
    assign out_tag    = tag_q;
    assign out_bypass = bypass_q;
    assign out_sign   = sign_q;
    assign out_nan    = nan_q;
    assign out_inf    = inf_q;
    assign out_zero   = zero_q;

endmodule

// File: doc/fp_special_ctrl.md
FP_SPECIAL_CTRL -- requirements
Module: fp_special_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3: multiplier datapath latency in cycles, legal range 1..15.
REQ-002 SHALL have parameter TAG_W, default 4: width of the request tag.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): request handshake.
REQ-006 SHALL have port in_op, input, 2 bits: 00 MUL, 01 INV_S, 10 ABS_W, 11 reserved.
REQ-007 SHALL have ports in_a_flags and in_b_flags, inputs, 5 bits each: {sign, val, nan, inf, zero}.
REQ-008 SHALL have port in_tag, input, TAG_W bits: opaque request tag.
REQ-009 SHALL have ports dp_start (output, 1), dp_op (output, 2) and dp_tag (output, TAG_W): datapath issue.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-011 SHALL have ports out_tag (TAG_W), out_bypass, out_sign, out_nan, out_inf and out_zero (1 bit each), all outputs.
REQ-012 SHALL have port flush, input, 1 bit: abort the operation in flight.

Function
REQ-013 SHALL implement states IDLE, BUSY and HOLD; in_ready = (state==IDLE); one operation outstanding at most.
REQ-014 SHALL accept a request when in_valid && in_ready, registering op, tag and both flag vectors.
REQ-015 SHALL compute the result sign as: MUL a^b; INV_S ~(a^b); ABS_W 0; reserved 0.
REQ-016 SHALL set nan = either nan flag | (zero_a & inf_b) | (inf_a & zero_b) | (op==11).
REQ-017 SHALL set inf = !nan & (inf_a | inf_b), and zero = !nan & !inf & (zero_a | zero_b).
REQ-018 SHALL classify a request as special when nan | inf | zero.
REQ-019 Special request accepted in cycle T: SHALL go IDLE->HOLD, with out_valid=1 from T+1, out_bypass=1 and the computed flags/sign driven; dp_start SHALL NOT pulse.
REQ-020 Normal request accepted in cycle T: SHALL go IDLE->BUSY, pulse dp_start for exactly one cycle in T+1 with dp_op/dp_tag = the registered op/tag, and load the down-counter with MUL_LAT.
REQ-021 In BUSY, the counter SHALL decrement each cycle; at zero, SHALL go BUSY->HOLD, with out_valid first high in cycle T+1+MUL_LAT, out_bypass=0, nan/inf/zero=0 and sign per REQ-015.
REQ-022 In HOLD, SHALL hold out_valid and all out_* stable until out_ready=1, then go HOLD->IDLE; in_ready rises the following cycle, with no same-cycle re-accept.
REQ-023 out_tag SHALL equal the accepted in_tag on both paths.
REQ-024 flush=1 SHALL force state IDLE at the next edge from any state; a pending dp_start pulse SHALL be suppressed.
REQ-025 An out_valid && out_ready handshake in a flush cycle SHALL count as delivered.
REQ-026 in_valid during BUSY/HOLD SHALL be ignored; inputs SHALL be sampled only at accept.

Reset
REQ-027 rst=1 SHALL force state IDLE, counter 0, and out_valid, dp_start, out_bypass, out_sign, out_nan, out_inf, out_zero = 0, with out_tag/dp_tag/dp_op = 0.
REQ-028 rst SHALL take priority over flush and all handshakes; asserting rst mid-BUSY or mid-HOLD SHALL discard the operation with no output produced.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-030 Macro FP_SPECIAL_BYPASS_EN defined: special requests SHALL take the bypass path per REQ-019.
REQ-031 Macro FP_SPECIAL_BYPASS_EN undefined: every request SHALL take the REQ-020/021 path with dp_start pulsed, and special flags SHALL be delivered at T+1+MUL_LAT with out_bypass=1.

Verification
REQ-032 MUL, a={1,1,0,0,0}, b={0,1,0,0,0}, tag 5, MUL_LAT=3, accept at cycle 0 -> dp_start at cycle 1; out_valid at cycle 4 with sign=1, bypass=0, tag=5.
REQ-033 MUL, a.zero=1, b.inf=1, macro defined -> out_valid at cycle 1 with nan=1, bypass=1, and no dp_start; macro undefined -> out_valid at cycle 4 with dp_start pulsed.
REQ-034 INV_S, both sign=0, a.zero=1 -> out_sign=1, out_zero=1, out_nan=0; ABS_W with a.sign=1, b.inf=1 -> sign=0, inf=1.
REQ-035 Normal result with out_ready=0 for 5 cycles -> out_valid and out_tag held stable; in_ready=0 throughout; in_ready=1 the cycle after out_ready=1.
REQ-036 flush at cycle 2 of BUSY -> IDLE next cycle, no out_valid; rst in HOLD -> all outputs 0 next cycle and in_ready=1 after release.
